// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port byte-masked SRAM among NUM_REQ requesters,
// with optional burst locking bounded to MAX_LOCK consecutive beats and a 1-cycle response.
module sram_rr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int WORD_DEPTH = 512,
    parameter  int MAX_LOCK   = 16,
    localparam int AW         = $clog2(WORD_DEPTH),
    localparam int BW         = DATA_WIDTH / 8
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0]                 req_lock_i,
    input  logic [NUM_REQ-1:0]                 req_wen_i,
    input  logic [NUM_REQ-1:0][AW-1:0]         req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_REQ-1:0][BW-1:0]         req_bm_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic                               rsp_wr_o,
    output logic [DATA_WIDTH-1:0]              rsp_rdata_o,
    output logic                               sram_en_o,
    output logic                               sram_wen_o,
    output logic [AW-1:0]                      sram_addr_o,
    output logic [BW-1:0]                      sram_bm_o,
    output logic [DATA_WIDTH-1:0]              sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]              sram_rdata_i
);

    localparam int PW  = $clog2(NUM_REQ);
    localparam int LCW = $clog2(MAX_LOCK) + 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(NUM_REQ - 1)) ? '0 : v + PW'(1);
    endfunction

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      last_q;
    logic [LCW-1:0]     lock_cnt_q;
    logic               locked_q;

    logic               hold;
    logic               rr_found;
    logic [PW-1:0]      rr_idx;
    logic [PW-1:0]      rr_cand;
    logic               gnt_any_p0;
    logic [PW-1:0]      gnt_idx_p0;
    logic [NUM_REQ-1:0] gnt_p0;
    logic [NUM_REQ-1:0] rsp_vld_p1;
    logic               rsp_wr_p1;

    // ---- Stage p0: arbitration and SRAM request mux (combinational) ----
    // A lock is honoured only while the beat budget is not exhausted; at the limit the
    // round-robin search starts just past last_q, so every other requester gets first claim.
    assign hold = locked_q & req_valid_i[last_q] & (lock_cnt_q < LOCK_LAST);

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && req_valid_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
            rr_cand = wrap_inc(rr_cand);
        end
    end

    always_comb begin
        gnt_any_p0 = 1'b0;
        gnt_idx_p0 = '0;
        if (aresetn) begin
            if (hold) begin
                gnt_any_p0 = 1'b1;
                gnt_idx_p0 = last_q;
            end else if (rr_found) begin
                gnt_any_p0 = 1'b1;
                gnt_idx_p0 = rr_idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_p0[i] = gnt_any_p0 & (gnt_idx_p0 == PW'(i));
        end
    end

    always_comb begin
        sram_wen_o   = 1'b0;
        sram_addr_o  = '0;
        sram_bm_o    = '0;
        sram_wdata_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_p0[i]) begin
                sram_wen_o   = req_wen_i[i];
                sram_addr_o  = req_addr_i[i];
                sram_bm_o    = req_bm_i[i];
                sram_wdata_o = req_wdata_i[i];
            end
        end
    end

    assign req_ready_o = gnt_p0;
    assign sram_en_o   = gnt_any_p0;

    // ---- Stage p1: arbiter state update and response pipeline ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q      <= '0;
            last_q     <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            rsp_vld_p1 <= '0;
            rsp_wr_p1  <= 1'b0;
        end else begin
            rsp_vld_p1 <= gnt_p0;
            rsp_wr_p1  <= sram_wen_o;
            if (gnt_any_p0) begin
                ptr_q      <= wrap_inc(gnt_idx_p0);
                last_q     <= gnt_idx_p0;
                locked_q   <= req_lock_i[gnt_idx_p0];
                lock_cnt_q <= hold ? lock_cnt_q + LCW'(1) : '0;
            end else begin
                locked_q   <= 1'b0;
                lock_cnt_q <= '0;
            end
        end
    end

    assign rsp_valid_o = rsp_vld_p1;
    assign rsp_wr_o    = rsp_wr_p1;
    assign rsp_rdata_o = sram_rdata_i;

endmodule
